// File: rtl/axi_mem_pkg.sv
// Shared types for axi_mem_responder: AXI response codes, the INCR burst
// encoding and the write/read channel state enums.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    StWrIdle,
    StWrData,
    StWrResp
  } wr_state_e;

  typedef enum logic {
    StRdIdle,
    StRdData
  } rd_state_e;

endpackage

// File: rtl/axi_mem_responder.sv
// AXI4 memory-mapped responder backed by an internal word array with byte-enable
// writes. One outstanding write (AW/W/B) and one outstanding read (AR/R), running
// concurrently. Bursts are treated as INCR and beats as full width.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  - write address, data and response channels
//   s_axi_ar* / s_axi_r*             - read address and data channels
//
// Optional feature macro: AXI_MEM_RESP_ERR_CHECK_EN
//   When defined, a non-INCR burst or a wlast that disagrees with the final-beat
//   position makes that transaction answer SLVERR. Non-INCR writes are dropped and
//   non-INCR reads return zeros (with the full beat count).
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned MEM_ADDR_BITS = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned NB       = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(NB);
  localparam int unsigned IDX_BITS = MEM_ADDR_BITS - OFF_BITS;
  localparam int unsigned DEPTH    = 2 ** IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;

  // Fields the responder deliberately ignores (size, upper/offset address bits).
  logic unused_in;
  assign unused_in = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize,
                       s_axi_awburst, s_axi_arburst, s_axi_wlast};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Low while reset was sampled at the last edge, so the idle readies only rise
  // the cycle after reset is released.
  logic live_q;

  wr_state_e wr_state_q, wr_state_d;
  idx_t      wr_idx_q, wr_idx_d;
  logic [7:0] wr_len_q, wr_len_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic      mem_we;

  rd_state_e rd_state_q, rd_state_d;
  idx_t      rd_idx_q, rd_idx_d;
  logic [7:0] rd_len_q, rd_len_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic      rlast_q, rlast_d;
  idx_t      ar_idx;

`ifdef AXI_MEM_RESP_ERR_CHECK_EN
  logic wr_bad_q, wr_bad_d;  // non-INCR: suppress commits
  logic wr_err_q, wr_err_d;  // sticky SLVERR for the current write
  logic rd_bad_q, rd_bad_d;  // non-INCR read: zeros + SLVERR
`endif

  assign ar_idx = s_axi_araddr[MEM_ADDR_BITS-1:OFF_BITS];

  // Write channel
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_idx_d      = wr_idx_q;
    wr_len_d      = wr_len_q;
    wr_cnt_d      = wr_cnt_q;
    mem_we        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
    wr_bad_d      = wr_bad_q;
    wr_err_d      = wr_err_q;
`endif
    unique case (wr_state_q)
      StWrIdle: begin
        s_axi_awready = live_q;
        if (live_q && s_axi_awvalid) begin
          wr_idx_d   = s_axi_awaddr[MEM_ADDR_BITS-1:OFF_BITS];
          wr_len_d   = s_axi_awlen;
          wr_cnt_d   = 8'd0;
          wr_state_d = StWrData;
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
          wr_bad_d   = (s_axi_awburst != BURST_INCR);
          wr_err_d   = (s_axi_awburst != BURST_INCR);
`endif
        end
      end
      StWrData: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
          mem_we = !wr_bad_q;
          if (s_axi_wlast != (wr_cnt_q == wr_len_q)) wr_err_d = 1'b1;
`else
          mem_we = 1'b1;
`endif
          wr_idx_d = wr_idx_q + idx_t'(1);
          wr_cnt_d = wr_cnt_q + 8'd1;
          // Beat count alone ends the burst; wlast is not trusted for this.
          if (wr_cnt_q == wr_len_q) wr_state_d = StWrResp;
        end
      end
      StWrResp: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_d = StWrIdle;
      end
      default: wr_state_d = StWrIdle;
    endcase
  end

`ifdef AXI_MEM_RESP_ERR_CHECK_EN
  assign s_axi_bresp = wr_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rresp = rd_bad_q ? RESP_SLVERR : RESP_OKAY;
`else
  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;
`endif

  // Read channel. Memory is read combinationally before this edge's write lands,
  // so a same-word write and read-load returns the old data.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_idx_d      = rd_idx_q;
    rd_len_d      = rd_len_q;
    rd_cnt_d      = rd_cnt_q;
    rdata_d       = rdata_q;
    rlast_d       = rlast_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
    rd_bad_d      = rd_bad_q;
`endif
    unique case (rd_state_q)
      StRdIdle: begin
        s_axi_arready = live_q;
        if (live_q && s_axi_arvalid) begin
          rdata_d    = mem_q[ar_idx];
          rlast_d    = (s_axi_arlen == 8'd0);
          rd_idx_d   = ar_idx + idx_t'(1);
          rd_len_d   = s_axi_arlen;
          rd_cnt_d   = 8'd0;
          rd_state_d = StRdData;
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
          rd_bad_d   = (s_axi_arburst != BURST_INCR);
          if (s_axi_arburst != BURST_INCR) rdata_d = '0;
`endif
        end
      end
      StRdData: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (rlast_q) begin
            rd_state_d = StRdIdle;
          end else begin
            // Load the next beat in the same cycle to avoid a bubble.
            rdata_d  = mem_q[rd_idx_q];
            rd_idx_d = rd_idx_q + idx_t'(1);
            rd_cnt_d = rd_cnt_q + 8'd1;
            rlast_d  = ((rd_cnt_q + 8'd1) == rd_len_q);
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
            if (rd_bad_q) rdata_d = '0;
`endif
          end
        end
      end
      default: rd_state_d = StRdIdle;
    endcase
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rlast = rlast_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q     <= 1'b0;
      wr_state_q <= StWrIdle;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      rd_state_q <= StRdIdle;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
      wr_bad_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_bad_q   <= 1'b0;
`endif
    end else begin
      live_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
      wr_bad_q   <= wr_bad_d;
      wr_err_q   <= wr_err_d;
      rd_bad_q   <= rd_bad_d;
`endif
    end
  end

  // Storage is not reset; byte lanes are written only where the strobe is set.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (s_axi_wstrb[i]) mem_q[wr_idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed cases plus randomized bursts,
// compared against a byte-level memory model with a per-byte "known" mask.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 256;
  localparam int unsigned MAB   = 18;
  localparam int unsigned NB    = DW / 8;
  localparam int          DEPTH = (2 ** MAB) / NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic [2:0]    s_axi_awsize;
  logic [1:0]    s_axi_awburst;
  logic          s_axi_awvalid, s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [NB-1:0] s_axi_wstrb;
  logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid, s_axi_bready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_mem_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_ADDR_BITS(MAB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awlen  (s_axi_awlen),
    .s_axi_awsize (s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wlast  (s_axi_wlast),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arlen  (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready)
  );

  // Reference model: word contents plus which bytes have ever been written.
  logic [DW-1:0] ref_mem   [DEPTH];
  logic [NB-1:0] ref_known [DEPTH];
  logic [DW-1:0] w_data    [256];
  logic [NB-1:0] w_strb    [256];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return (int'(a) / int'(NB)) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(NB); i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic burst_ok(input logic [1:0] burst);
`ifdef AXI_MEM_RESP_ERR_CHECK_EN
    return burst == BURST_INCR;
`else
    return burst == burst;
`endif
  endfunction

  // Burst of len+1 beats from w_data/w_strb; updates the model on each accepted beat.
  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst);
    int n;
    int idx;
    logic [DW-1:0] m;
    logic [1:0] exp_resp;
    idx      = word_of(addr);
    exp_resp = burst_ok(burst) ? RESP_OKAY : RESP_SLVERR;
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    s_axi_awsize  = 3'd5;
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    check_val("aw_accept", DW'(s_axi_awready), DW'(1'b1));
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    check_val("wready_latency", DW'(s_axi_wready), DW'(1'b1));
    for (int b = 0; b <= len; b++) begin
      s_axi_wdata  = w_data[b];
      s_axi_wstrb  = w_strb[b];
      s_axi_wlast  = (b == len);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin @(posedge clk); #1; n++; end
      check_val("w_accept", DW'(s_axi_wready), DW'(1'b1));
      @(posedge clk); #1;
      if (burst_ok(burst)) begin
        m = byte_mask(w_strb[b]);
        ref_mem[idx]   = (ref_mem[idx] & ~m) | (w_data[b] & m);
        ref_known[idx] = ref_known[idx] | w_strb[b];
      end
      idx = (idx + 1) % DEPTH;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check_val("bvalid_latency", DW'(s_axi_bvalid), DW'(1'b1));
    check_val("bresp", DW'(s_axi_bresp), DW'(exp_resp));
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
      check_val("bvalid_hold", DW'(s_axi_bvalid), DW'(1'b1));
      check_val("bresp_hold", DW'(s_axi_bresp), DW'(exp_resp));
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check_val("b_done", DW'(s_axi_bvalid), DW'(1'b0));
  endtask

  // mode 0: rready always high, 1: toggling (stall first), 2: random.
  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input int mode);
    int n;
    int b;
    int idx;
    logic rdy;
    logic ok;
    logic [DW-1:0] m;
    logic [DW-1:0] exp;
    idx = word_of(addr);
    ok  = burst_ok(burst);
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arsize  = 3'd5;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    check_val("ar_accept", DW'(s_axi_arready), DW'(1'b1));
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check_val("rvalid_latency", DW'(s_axi_rvalid), DW'(1'b1));
    b = 0;
    n = 0;
    while (b <= len && n < 4 * (len + 1) + 10) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rdy;
      exp = ok ? ref_mem[idx] : '0;
      m   = ok ? byte_mask(ref_known[idx]) : '1;
      check_val("rvalid", DW'(s_axi_rvalid), DW'(1'b1));
      check_val("rdata", s_axi_rdata & m, exp & m);
      check_val("rlast", DW'(s_axi_rlast), DW'(b == len));
      check_val("rresp", DW'(s_axi_rresp), DW'(ok ? RESP_OKAY : RESP_SLVERR));
      @(posedge clk); #1;
      if (rdy) begin
        b++;
        idx = (idx + 1) % DEPTH;
      end
      n++;
    end
    s_axi_rready = 1'b0;
    check_val("r_beats", DW'(b), DW'(len + 1));
    check_val("r_done", DW'(s_axi_rvalid), DW'(1'b0));
    check_val("r_idle_arready", DW'(s_axi_arready), DW'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int len;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = '0;
    end
    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = BURST_INCR;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = BURST_INCR;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_awready", DW'(s_axi_awready), DW'(1'b0));
    check_val("rst_wready", DW'(s_axi_wready), DW'(1'b0));
    check_val("rst_bvalid", DW'(s_axi_bvalid), DW'(1'b0));
    check_val("rst_arready", DW'(s_axi_arready), DW'(1'b0));
    check_val("rst_rvalid", DW'(s_axi_rvalid), DW'(1'b0));
    check_val("rst_rlast", DW'(s_axi_rlast), DW'(1'b0));
    check_val("rst_rdata", s_axi_rdata, '0);
    check_val("rst_resp", DW'({s_axi_bresp, s_axi_rresp}), DW'(4'b0000));
    reset = 1'b0;
    check_val("rel_awready_same", DW'(s_axi_awready), DW'(1'b0));
    @(posedge clk); #1;
    check_val("rel_awready", DW'(s_axi_awready), DW'(1'b1));
    check_val("rel_arready", DW'(s_axi_arready), DW'(1'b1));

    // Single beat at 0x40
    w_data[0] = {NB{8'hA5}};
    w_strb[0] = '1;
    axi_write(64'h40, 0, BURST_INCR);
    axi_read(64'h40, 0, BURST_INCR, 0);

    // 16-beat INCR of beat indices, read back streaming then with stalls
    for (int b = 0; b < 16; b++) begin
      w_data[b] = DW'(b);
      w_strb[b] = '1;
    end
    axi_write(64'h0, 15, BURST_INCR);
    axi_read(64'h0, 15, BURST_INCR, 0);
    axi_read(64'h0, 15, BURST_INCR, 1);

    // Partial strobe over an all-ones word
    w_data[0] = '1;
    w_strb[0] = '1;
    axi_write(64'h100, 0, BURST_INCR);
    w_data[0] = rand_word();
    w_strb[0] = 32'h0000_000F;
    axi_write(64'h100, 0, BURST_INCR);
    axi_read(64'h100, 0, BURST_INCR, 2);

    // Wrap from the last word to word 0
    w_data[0] = rand_word(); w_strb[0] = '1;
    w_data[1] = rand_word(); w_strb[1] = '1;
    axi_write(64'h3FFE0, 1, BURST_INCR);
    axi_read(64'h3FFE0, 1, BURST_INCR, 0);

    // Upper address bits and byte offset ignored
    axi_read(64'hABCD_0000_0004_0047, 0, BURST_INCR, 0);

    // Randomized bursts, each read back with random back-pressure
    for (int t = 0; t < 20; t++) begin
      a   = AW'($urandom_range(0, DEPTH - 1)) * AW'(NB) + AW'($urandom_range(0, NB - 1));
      len = $urandom_range(0, 15);
      for (int b = 0; b <= len; b++) begin
        w_data[b] = rand_word();
        w_strb[b] = ($urandom_range(0, 1) == 1) ? '1 : NB'({$urandom()});
      end
      axi_write(a, len, BURST_INCR);
      axi_read(a, len, BURST_INCR, 2);
    end

    // Reset during a 16-beat read: abort, no further beats
    s_axi_araddr  = 64'h0;
    s_axi_arlen   = 8'd15;
    s_axi_arburst = BURST_INCR;
    s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_rdata", s_axi_rdata, DW'(3));
    reset        = 1'b1;
    s_axi_rready = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rst_rvalid", DW'(s_axi_rvalid), DW'(1'b0));
    check_val("mid_rst_arready", DW'(s_axi_arready), DW'(1'b0));
    check_val("mid_rst_rdata", s_axi_rdata, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_arready", DW'(s_axi_arready), DW'(1'b1));
    check_val("post_rst_rvalid", DW'(s_axi_rvalid), DW'(1'b0));
    axi_read(64'h0, 15, BURST_INCR, 2);

`ifdef AXI_MEM_RESP_ERR_CHECK_EN
    // FIXED burst write: SLVERR and memory untouched
    w_data[0] = rand_word();
    w_strb[0] = '1;
    axi_write(64'h40, 0, 2'b00);
    axi_read(64'h40, 0, BURST_INCR, 0);
    axi_read(64'h40, 1, 2'b10, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
